rtc_bus_interface: RTL and testbench

RTC_BUS_INTERFACE -- requirements
Module: rtc_bus_interface

---
 rtl/rtc_bus_interface_if.sv | 31 +++
 rtl/rtc_bus_interface.sv | 150 +++++++++++++++
 tb/tb_rtc_bus_interface.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/rtc_bus_interface_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rtc_bus_interface_if
// Description : Host handshake plus RTC strobe signals for rtc_bus_interface.
// Revision    : 1.0 - initial release
// ============================================================================
interface rtc_bus_interface_if;
    logic       start;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       a_d;
    logic       cs;
    logic       rd;
    logic       wr;

    modport master (
        output start, rw, addr, wdata,
        input  rdata, busy, done, a_d, cs, rd, wr
    );

    modport slave (
        input  start, rw, addr, wdata,
        output rdata, busy, done, a_d, cs, rd, wr
    );
endinterface
`default_nettype wire

// File: rtl/rtc_bus_interface.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rtc_bus_interface
// Description : Multiplexed address/data bus master for an external RTC chip.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_interface #(
    parameter int PHASE_CYC = 10
) (
    input  wire                  clk,
    input  wire                  reset,
    rtc_bus_interface_if.slave   bus,
    inout  wire [7:0]            dato
);

    localparam logic [7:0] c_phase_last = 8'(PHASE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADR_STB = 3'd1,
        S_ADR_HLD = 3'd2,
        S_DAT_STB = 3'd3,
        S_DAT_HLD = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_phase;
    logic       r_rw;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;

    logic       w_phase_last;
    logic       w_a_d;
    logic       w_cs;
    logic       w_rd;
    logic       w_wr;
    logic       w_busy;
    logic       w_done;
    logic       w_dato_oe;
    logic [7:0] w_dato;

    assign w_phase_last = (r_phase == c_phase_last);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_phase <= 8'd0;
            r_rw    <= 1'b0;
            r_addr  <= 8'h00;
            r_wdata <= 8'h00;
            r_rdata <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            // Counter restarts on every state change, so it never wraps in place.
            if (w_state_nxt != r_state) begin
                r_phase <= 8'd0;
            end else if (r_state != S_IDLE && r_state != S_FIN) begin
                r_phase <= r_phase + 8'd1;
            end
            if (r_state == S_IDLE && bus.start) begin
                r_rw    <= bus.rw;
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
            end
            if (r_state == S_DAT_STB && r_rw && w_phase_last) begin
                r_rdata <= dato;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a_d       = 1'b1;
        w_cs        = 1'b1;
        w_rd        = 1'b1;
        w_wr        = 1'b1;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_dato_oe   = 1'b0;
        w_dato      = r_addr;

        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state_nxt = S_ADR_STB;
                end
            end
            S_ADR_STB: begin
                w_a_d     = 1'b0;
                w_cs      = 1'b0;
                w_wr      = 1'b0;
                w_dato_oe = 1'b1;
                if (w_phase_last) begin
                    w_state_nxt = S_ADR_HLD;
                end
            end
            S_ADR_HLD: begin
                w_a_d     = 1'b0;
                w_dato_oe = 1'b1;
                if (w_phase_last) begin
                    w_state_nxt = S_DAT_STB;
                end
            end
            S_DAT_STB: begin
                w_cs = 1'b0;
                if (r_rw) begin
                    w_rd = 1'b0;
                end else begin
                    w_wr      = 1'b0;
                    w_dato_oe = 1'b1;
                    w_dato    = r_wdata;
                end
                if (w_phase_last) begin
                    w_state_nxt = S_DAT_HLD;
                end
            end
            S_DAT_HLD: begin
                w_dato_oe = !r_rw;
                w_dato    = r_wdata;
                if (w_phase_last) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign dato      = w_dato_oe ? w_dato : 8'hzz;
    assign bus.a_d   = w_a_d;
    assign bus.cs    = w_cs;
    assign bus.rd    = w_rd;
    assign bus.wr    = w_wr;
    assign bus.busy  = w_busy;
    assign bus.done  = w_done;
    assign bus.rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_interface.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rtc_bus_interface
// Description : Directed self-checking bench for rtc_bus_interface with RTC model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_interface;

    localparam int PHASE_CYC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rtc_val;
    logic [7:0] model_rdata;
    wire  [7:0] dato;

    int n_checks = 0;
    int n_errors = 0;
    int n_viol   = 0;

    rtc_bus_interface_if bus();

    // RTC chip model: drives the bus only while it is selected and read-strobed.
    wire rtc_oe = !bus.cs && !bus.rd;
    assign dato = rtc_oe ? rtc_val : 8'hzz;

    rtc_bus_interface #(.PHASE_CYC(PHASE_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .dato  (dato)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (!bus.rd && !bus.wr)      n_viol++;
            if (!bus.rd && dut.w_dato_oe) n_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {busy, done, a_d, cs, rd, wr} for cycle c after acceptance (PHASE_CYC=4)
    function automatic logic [5:0] exp_ctrl(input int c, input logic r);
        if (c <= 4)       return 6'b100010;
        else if (c <= 8)  return 6'b100111;
        else if (c <= 12) return r ? 6'b101001 : 6'b101010;
        else if (c <= 16) return 6'b101111;
        else if (c == 17) return 6'b111111;
        else              return 6'b001111;
    endfunction

    function automatic logic [5:0] ctrl_now();
        return {bus.busy, bus.done, bus.a_d, bus.cs, bus.rd, bus.wr};
    endfunction

    task automatic run_txn(input logic r, input logic [7:0] a, input logic [7:0] wd,
                           input bit glitch, input bit hold);
        @(negedge clk);
        bus.rw = r; bus.addr = a; bus.wdata = wd; bus.start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 18; c++) begin
            if (c > 1) @(posedge clk);
            #1;
            if (c == 1 && !hold) bus.start = 1'b0;
            check($sformatf("ctrl a=%0h c%0d", a, c), ctrl_now(), exp_ctrl(c, r));
            if (c <= 8)
                check($sformatf("dato_addr c%0d", c), dato, a);
            else if (c <= 12 && r)
                check($sformatf("dato_rtc c%0d", c), dato, rtc_val);
            else if (c <= 16 && !r)
                check($sformatf("dato_wdata c%0d", c), dato, wd);
            if (r && c == 13) model_rdata = rtc_val;
            check($sformatf("rdata a=%0h c%0d", a, c), bus.rdata, model_rdata);
            if (glitch && (c == 3 || c == 10)) begin
                bus.start = 1'b1; bus.addr = ~a; bus.wdata = ~wd; bus.rw = ~r;
            end else if (!hold) begin
                bus.start = 1'b0; bus.addr = a; bus.wdata = wd; bus.rw = r;
            end
        end
    endtask

    initial begin
        int done_cnt;
        reset       = 1'b0;
        bus.start   = 1'b1;
        bus.rw      = 1'b1;
        bus.addr    = 8'h99;
        bus.wdata   = 8'h00;
        rtc_val     = 8'h37;
        model_rdata = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", ctrl_now(), 6'b001111);
        check("reset_rdata", bus.rdata, 8'h00);
        @(negedge clk);
        reset = 1'b1; bus.start = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", ctrl_now(), 6'b001111);

        run_txn(1'b0, 8'h21, 8'h45, 1'b0, 1'b0);
        run_txn(1'b1, 8'h22, 8'h00, 1'b0, 1'b0);
        check("read_rdata_37", bus.rdata, 8'h37);

        run_txn(1'b0, 8'h5c, 8'ha3, 1'b1, 1'b0);
        rtc_val = 8'hc4;
        run_txn(1'b1, 8'h33, 8'h00, 1'b1, 1'b0);

        // start held high: back-to-back every 18 cycles
        rtc_val = 8'h81;
        run_txn(1'b1, 8'h10, 8'h00, 1'b0, 1'b1);
        run_txn(1'b0, 8'h11, 8'h7e, 1'b0, 1'b1);
        run_txn(1'b0, 8'h12, 8'h01, 1'b0, 1'b0);

        // Abort a read during its data strobe
        rtc_val = 8'h5a;
        @(negedge clk);
        bus.rw = 1'b1; bus.addr = 8'h40; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort_pre_datstb", ctrl_now(), exp_ctrl(10, 1'b1));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_ctrl", ctrl_now(), 6'b001111);
        check("abort_rdata", bus.rdata, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_rdata_hold", bus.rdata, 8'h00);

        model_rdata = 8'h00;
        rtc_val     = 8'h37;
        run_txn(1'b1, 8'h22, 8'h00, 1'b0, 1'b0);

        check("bus_rules", n_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
